// File: rtl/averager_mc_if.sv
// Tagged sample stream into the multi-channel averager and the registered average back out.
// Signal names follow the block's port list; master drives samples, slave is the filter.
interface averager_mc_if #(
    parameter int N         = 12,
    parameter int MAX_POWER = 8,
    parameter int CH        = 5
);
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int WSW = $clog2(MAX_POWER + 1);

    logic           EN;
    logic [CW-1:0]  ch_id;
    logic [N-1:0]   Din;
    logic           win_load;
    logic [WSW-1:0] win_sel;
    logic [N-1:0]   Q;
    logic [CW-1:0]  Q_ch;
    logic           Q_valid;
    logic           Q_full;
    logic [WSW-1:0] win_cur;

    modport master (
        output EN, ch_id, Din, win_load, win_sel,
        input  Q, Q_ch, Q_valid, Q_full, win_cur
    );

    modport slave (
        input  EN, ch_id, Din, win_load, win_sel,
        output Q, Q_ch, Q_valid, Q_full, win_cur
    );
endinterface

// File: rtl/averager_mc.sv
// Multi-channel moving-average filter with a run-time power-of-two window.
// Each channel keeps its own history ring, running sum and fill count; output is registered.
module averager_mc #(
    parameter int N             = 12,
    parameter int MAX_POWER     = 8,
    parameter int CH            = 5,
    parameter int DEFAULT_POWER = 8
) (
    input  logic         clk,
    input  logic         reset,
    averager_mc_if.slave bus
);
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int WSW   = $clog2(MAX_POWER + 1);
    localparam int SW    = N + MAX_POWER;
    localparam int DEPTH = 2 ** MAX_POWER;

    logic [N-1:0]         hist_q  [CH][DEPTH];
    logic [SW-1:0]        sum_q   [CH];
    logic [MAX_POWER-1:0] wptr_q  [CH];
    logic [MAX_POWER:0]   fill_q  [CH];
    logic [WSW-1:0]       win_cur_q;
    logic [N-1:0]         q_q;
    logic [CW-1:0]        q_ch_q;
    logic                 q_valid_q;
    logic                 q_full_q;

    logic                 ch_ok;
    logic                 accept;
    logic [CW-1:0]        sel;
    logic [MAX_POWER:0]   w_full;
    logic [MAX_POWER-1:0] rd_ptr;
    logic                 was_full;
    logic [N-1:0]         old_d;
    logic [SW-1:0]        sum_d;
    logic [MAX_POWER:0]   fill_d;
    logic [N-1:0]         q_d;
    logic [WSW-1:0]       win_sel_clamped;

    // Extra MSB on the tag so CH equal to a power of two still compares correctly.
    assign ch_ok  = ({1'b0, bus.ch_id} < (CW + 1)'(CH));
    assign accept = bus.EN && !bus.win_load && ch_ok;
    assign sel    = ch_ok ? bus.ch_id : '0;

    always_comb begin
        w_full   = (MAX_POWER + 1)'(1) << win_cur_q;
        // W == DEPTH wraps to zero here, which lands on the slot about to be overwritten.
        rd_ptr   = wptr_q[sel] - w_full[MAX_POWER-1:0];
        was_full = (fill_q[sel] == w_full);
        old_d    = was_full ? hist_q[sel][rd_ptr] : '0;
        sum_d    = sum_q[sel] + SW'(bus.Din) - SW'(old_d);
        fill_d   = was_full ? fill_q[sel] : fill_q[sel] + 1'b1;
        q_d      = N'(sum_d >> win_cur_q);
    end

    assign win_sel_clamped = (bus.win_sel > WSW'(MAX_POWER)) ? WSW'(MAX_POWER) : bus.win_sel;

    // History RAM is never cleared; fill counts gate every read of stale entries.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            hist_q[sel][wptr_q[sel]] <= bus.Din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                sum_q[c]  <= '0;
                wptr_q[c] <= '0;
                fill_q[c] <= '0;
            end
            win_cur_q <= WSW'(DEFAULT_POWER);
            q_q       <= '0;
            q_ch_q    <= '0;
            q_valid_q <= 1'b0;
            q_full_q  <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            if (bus.win_load) begin
                for (int c = 0; c < CH; c++) begin
                    sum_q[c]  <= '0;
                    wptr_q[c] <= '0;
                    fill_q[c] <= '0;
                end
                win_cur_q <= win_sel_clamped;
            end else if (accept) begin
                sum_q[sel]  <= sum_d;
                wptr_q[sel] <= wptr_q[sel] + 1'b1;
                fill_q[sel] <= fill_d;
                q_q         <= q_d;
                q_ch_q      <= bus.ch_id;
                q_valid_q   <= 1'b1;
                q_full_q    <= (fill_d == w_full);
            end
        end
    end

    assign bus.Q       = q_q;
    assign bus.Q_ch    = q_ch_q;
    assign bus.Q_valid = q_valid_q;
    assign bus.Q_full  = q_full_q;
    assign bus.win_cur = win_cur_q;
endmodule

// File: tb/tb_averager_mc.sv
// Bench for averager_mc: a per-channel sample-queue model feeds a scoreboard of expected outputs,
// and a monitor compares every Q_valid beat against it.
module tb_averager_mc;
    localparam int N  = 12;
    localparam int MP = 8;
    localparam int CH = 5;

    logic clk = 1'b0;
    logic reset;

    averager_mc_if #(.N(N), .MAX_POWER(MP), .CH(CH)) bus ();

    averager_mc #(.N(N), .MAX_POWER(MP), .CH(CH), .DEFAULT_POWER(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] q;
        logic [2:0]  ch;
        logic        full;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned mh[CH][$];
    int          mwin;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk) begin
        #1;
        if (bus.Q_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got Q=%0d ch=%0d, none expected", bus.Q, bus.Q_ch);
            end else begin
                mon_e = sb.pop_front();
                if ({bus.Q, bus.Q_ch, bus.Q_full} !== {mon_e.q, mon_e.ch, mon_e.full}) begin
                    bad++;
                    $display("FAIL output got Q=%0d ch=%0d full=%0b expected Q=%0d ch=%0d full=%0b",
                             bus.Q, bus.Q_ch, bus.Q_full, mon_e.q, mon_e.ch, mon_e.full);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    task automatic model_clear();
        for (int c = 0; c < CH; c++) mh[c].delete();
    endtask

    // One clock cycle of stimulus, entered and left on the falling edge.
    task automatic cyc(input bit en, input int ch, input int din, input bit wl, input int ws);
        exp_t        e;
        int unsigned s;
        bus.EN       = en;
        bus.ch_id    = 3'(ch);
        bus.Din      = 12'(din);
        bus.win_load = wl;
        bus.win_sel  = 4'(ws);
        if (wl) begin
            mwin = (ws > MP) ? MP : ws;
            model_clear();
        end else if (en && ch < CH) begin
            mh[ch].push_back(din);
            if (mh[ch].size() > (1 << mwin)) void'(mh[ch].pop_front());
            s = 0;
            for (int i = 0; i < mh[ch].size(); i++) s += mh[ch][i];
            e.q    = 12'(s >> mwin);
            e.ch   = 3'(ch);
            e.full = (mh[ch].size() == (1 << mwin));
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.EN       = 1'b0;
        bus.win_load = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.EN       = 1'b0;
        bus.win_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        mwin = 8;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.Q, bus.Q_ch, bus.Q_valid, bus.Q_full} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got Q=%0d ch=%0d v=%0b full=%0b expected all 0",
                     bus.Q, bus.Q_ch, bus.Q_valid, bus.Q_full);
        end
        total++;
        if (bus.win_cur !== 4'd8) begin
            bad++;
            $display("FAIL reset_win got %0d expected 8", bus.win_cur);
        end
    endtask

    task automatic test_fill();
        int vals[5] = '{4, 8, 12, 16, 20};
        cyc(0, 0, 0, 1, 2);
        foreach (vals[i]) cyc(1, 0, vals[i], 0, 0);
        idle(2);
        total++;
        if ({bus.Q, bus.Q_full, bus.win_cur} !== {12'd14, 1'b1, 4'd2}) begin
            bad++;
            $display("FAIL fill_hold got Q=%0d full=%0b win=%0d expected Q=14 full=1 win=2",
                     bus.Q, bus.Q_full, bus.win_cur);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL fill_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_interleave();
        cyc(0, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 100, 0, 0);
            cyc(1, 3, 40, 0, 0);
        end
        idle(2);
        total++;
        if ({bus.Q, bus.Q_ch, bus.Q_full} !== {12'd40, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL interleave_last got Q=%0d ch=%0d full=%0b expected Q=40 ch=3 full=1",
                     bus.Q, bus.Q_ch, bus.Q_full);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL interleave_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_full_scale();
        do_reset();
        for (int i = 0; i < 300; i++) cyc(1, 4, 4095, 0, 0);
        idle(2);
        total++;
        if ({bus.Q, bus.Q_ch, bus.Q_full} !== {12'd4095, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL full_scale got Q=%0d ch=%0d full=%0b expected Q=4095 ch=4 full=1",
                     bus.Q, bus.Q_ch, bus.Q_full);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL full_scale_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_window_edges();
        cyc(0, 0, 0, 1, 0);
        cyc(1, 2, 7, 0, 0);
        cyc(1, 2, 9, 0, 0);
        idle(1);
        total++;
        if ({bus.Q, bus.Q_full, bus.win_cur} !== {12'd9, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL win0 got Q=%0d full=%0b win=%0d expected Q=9 full=1 win=0",
                     bus.Q, bus.Q_full, bus.win_cur);
        end
        cyc(0, 0, 0, 1, 9);
        idle(1);
        total++;
        if (bus.win_cur !== 4'd8) begin
            bad++;
            $display("FAIL win_clamp got %0d expected 8", bus.win_cur);
        end
    endtask

    task automatic test_illegal();
        cyc(0, 0, 0, 1, 1);
        cyc(1, 0, 10, 0, 0);
        cyc(1, 5, 999, 0, 0);
        total++;
        if (bus.Q_valid !== 1'b0) begin
            bad++;
            $display("FAIL illegal_ch got valid=%0b expected 0", bus.Q_valid);
        end
        // Channel 0 continues as if the tag-5 sample never arrived.
        cyc(1, 0, 30, 0, 0);
        cyc(1, 0, 50, 1, 1);
        total++;
        if (bus.Q_valid !== 1'b0) begin
            bad++;
            $display("FAIL load_drop got valid=%0b expected 0", bus.Q_valid);
        end
        cyc(1, 0, 60, 0, 0);
        idle(1);
        total++;
        if ({bus.Q, bus.Q_full} !== {12'd30, 1'b0}) begin
            bad++;
            $display("FAIL load_clears got Q=%0d full=%0b expected Q=30 full=0", bus.Q, bus.Q_full);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL illegal_drain got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 1, 2);
        cyc(1, 0, 100, 0, 0);
        cyc(1, 0, 200, 0, 0);
        do_reset();
        total++;
        if ({bus.Q, bus.Q_ch, bus.Q_valid, bus.Q_full, bus.win_cur} !== {17'd0, 4'd8}) begin
            bad++;
            $display("FAIL reset_mid got Q=%0d ch=%0d v=%0b full=%0b win=%0d expected 0s win=8",
                     bus.Q, bus.Q_ch, bus.Q_valid, bus.Q_full, bus.win_cur);
        end
        cyc(1, 0, 256, 0, 0);
        idle(1);
        total++;
        if ({bus.Q, bus.Q_full} !== {12'd1, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid_sample got Q=%0d full=%0b expected Q=1 full=0", bus.Q, bus.Q_full);
        end
    endtask

    task automatic test_back_to_back();
        cyc(0, 0, 0, 1, 3);
        for (int i = 0; i < 80; i++) begin
            cyc(1, $urandom_range(7, 0), $urandom_range(4095, 0), 0, 0);
        end
        for (int i = 0; i < 20; i++) cyc(1, 2, 4000 - i * 100, 0, 0);
        idle(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.EN       = 1'b0;
        bus.ch_id    = '0;
        bus.Din      = '0;
        bus.win_load = 1'b0;
        bus.win_sel  = '0;
        mwin         = 8;
        @(negedge clk);
        test_reset();
        test_fill();
        test_interleave();
        test_full_scale();
        test_window_edges();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
